// File: rtl/local_mem_shared_ram_pkg.sv
// Shared types and widths for the local memory with an external request port.
package local_mem_shared_ram_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [BE_W-1:0]   be;
        logic [DATA_W-1:0] wdata;
    } ext_mem_req_t;

endpackage

// File: rtl/local_memory_interface.sv
// Core-side local memory bus: word address, enable, byte enables, write data and read data.
interface local_memory_interface;
    import local_mem_shared_ram_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic              en;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport slave (input addr, en, be, data_in, output data_out);
    modport master (output addr, en, be, data_in, input data_out);

endinterface

// File: rtl/local_mem_shared_ram_byte_en_ram.sv
// Single-port word array with per-lane write enables and a read-first registered output.
module byte_en_ram
    import local_mem_shared_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [BE_W-1:0]                we,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Read-first: rdata captures the word before any lane of it is written.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < int'(BE_W); i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/local_mem_shared_ram.sv
// Local memory shared between the core (strict priority, no stall) and a buffered
// external valid/ready request port that is serviced in core-idle cycles.
module local_mem_shared_ram
    import local_mem_shared_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    local_memory_interface.slave local_mem,
    input  logic                 ext_req_valid,
    output logic                 ext_req_ready,
    input  logic [ADDR_W-1:0]    ext_req_addr,
    input  logic                 ext_req_we,
    input  logic [BE_W-1:0]      ext_req_be,
    input  logic [DATA_W-1:0]    ext_req_wdata,
    output logic                 ext_rsp_valid,
    output logic [DATA_W-1:0]    ext_rsp_data
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    ext_mem_req_t      new_req;
    ext_mem_req_t      pend_req;
    logic              pend;
    logic              issue_c;
    logic              accept_c;

    logic              ram_en;
    logic [IDX_W-1:0]  ram_addr;
    logic [BE_W-1:0]   ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              core_vld_q;
    logic [DATA_W-1:0] core_hold;
    logic [DATA_W-1:0] rsp_hold;

    assign new_req = '{addr: ext_req_addr, we: ext_req_we, be: ext_req_be, wdata: ext_req_wdata};

    // A pending request only reaches the array in a cycle the core leaves idle.
    assign issue_c       = pend && !local_mem.en && rst_n;
    assign ext_req_ready = !pend || issue_c;
    assign accept_c      = ext_req_valid && ext_req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
        end else if (accept_c) begin
            pend <= 1'b1;
        end else if (issue_c) begin
            pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_c) begin
            pend_req <= new_req;
        end
    end

    // Arbitration mux into the single array port.
    always_comb begin
        ram_en    = 1'b0;
        ram_addr  = '0;
        ram_we    = '0;
        ram_wdata = '0;
        if (local_mem.en) begin
            ram_en    = 1'b1;
            ram_addr  = local_mem.addr[IDX_W-1:0];
            ram_we    = local_mem.be;
            ram_wdata = local_mem.data_in;
        end else if (issue_c) begin
            ram_en    = 1'b1;
            ram_addr  = pend_req.addr[IDX_W-1:0];
            ram_we    = pend_req.we ? pend_req.be : BE_W'(0);
            ram_wdata = pend_req.wdata;
        end
    end

    byte_en_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_vld_q    <= 1'b0;
            ext_rsp_valid <= 1'b0;
        end else begin
            core_vld_q    <= local_mem.en;
            ext_rsp_valid <= issue_c;
        end
    end

    // The shared array output is only fresh for one cycle; each port keeps its own copy
    // so external traffic never disturbs data_out and vice versa.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_hold <= '0;
            rsp_hold  <= '0;
        end else begin
            if (core_vld_q) begin
                core_hold <= ram_rdata;
            end
            if (ext_rsp_valid) begin
                rsp_hold <= ram_rdata;
            end
        end
    end

    assign local_mem.data_out = core_vld_q ? ram_rdata : core_hold;
    assign ext_rsp_data       = ext_rsp_valid ? ram_rdata : rsp_hold;

    // Upper address bits are ignored so both ports wrap around the array.
    generate
        if (IDX_W < ADDR_W) begin : g_wrap
            logic unused_addr_bits;
            assign unused_addr_bits = ^{local_mem.addr[ADDR_W-1:IDX_W], pend_req.addr[ADDR_W-1:IDX_W]};
        end
    endgenerate

endmodule

// File: tb/tb_local_mem_shared_ram.sv
// Self-checking bench: directed vector table, reset/pending sequence, and a randomized
// phase checked against a queue-based transaction model of the memory.
module tb_local_mem_shared_ram;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext_req_valid;
    logic        ext_req_ready;
    logic [29:0] ext_req_addr;
    logic        ext_req_we;
    logic [3:0]  ext_req_be;
    logic [31:0] ext_req_wdata;
    logic        ext_rsp_valid;
    logic [31:0] ext_rsp_data;

    local_memory_interface lm();

    local_mem_shared_ram #(.DEPTH_WORDS(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .local_mem     (lm),
        .ext_req_valid (ext_req_valid),
        .ext_req_ready (ext_req_ready),
        .ext_req_addr  (ext_req_addr),
        .ext_req_we    (ext_req_we),
        .ext_req_be    (ext_req_be),
        .ext_req_wdata (ext_req_wdata),
        .ext_rsp_valid (ext_rsp_valid),
        .ext_rsp_data  (ext_rsp_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        cen;
        logic [29:0] caddr;
        logic [3:0]  cbe;
        logic [31:0] cdata;
        logic        ev;
        logic [29:0] eaddr;
        logic        ewe;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic        x_rdy;
        logic        x_rv;
        logic        chk_rd;
        logic [31:0] x_rd;
        logic        chk_do;
        logic [31:0] x_do;
    } vec_t;

    typedef struct {
        int unsigned idx;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    // Transaction-level reference state
    logic [31:0] mem   [DEPTH];
    bit          known [DEPTH];
    mreq_t       pq[$];
    logic [31:0] exp_do, exp_rd;
    bit          exp_do_known, exp_rd_known;
    int          rsp_count;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cen, input logic [29:0] caddr, input logic [3:0] cbe,
                         input logic [31:0] cdata, input logic ev, input logic [29:0] eaddr,
                         input logic ewe, input logic [3:0] ebe, input logic [31:0] ewd);
        lm.en         = cen;
        lm.addr       = caddr;
        lm.be         = cbe;
        lm.data_in    = cdata;
        ext_req_valid = ev;
        ext_req_addr  = eaddr;
        ext_req_we    = ewe;
        ext_req_be    = ebe;
        ext_req_wdata = ewd;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    task automatic model_write(input int unsigned idx, input logic [3:0] be, input logic [31:0] d);
        mem[idx] = merge(mem[idx], d, be);
        if (be == 4'hF) known[idx] = 1'b1;
    endtask

    // One clock cycle driven with the given inputs, predicted by the reference model.
    task automatic step(input logic cen, input logic [29:0] caddr, input logic [3:0] cbe,
                        input logic [31:0] cdata, input logic ev, input logic [29:0] eaddr,
                        input logic ewe, input logic [3:0] ebe, input logic [31:0] ewd);
        bit    rdy, rv;
        mreq_t r;
        int unsigned ci;
        @(negedge clk);
        drive(cen, caddr, cbe, cdata, ev, eaddr, ewe, ebe, ewd);
        #1;
        rdy = (pq.size() == 0) || !cen;
        check("model_ready", 32'(ext_req_ready), 32'(rdy));
        rv = 1'b0;
        if (cen) begin
            ci = caddr % DEPTH;
            exp_do = mem[ci];
            exp_do_known = known[ci];
            model_write(ci, cbe, cdata);
        end else if (pq.size() > 0) begin
            r = pq.pop_front();
            exp_rd = mem[r.idx];
            exp_rd_known = known[r.idx];
            if (r.we) model_write(r.idx, r.be, r.wdata);
            rv = 1'b1;
        end
        if (ev && rdy) pq.push_back('{idx: eaddr % DEPTH, we: ewe, be: ebe, wdata: ewd});
        @(posedge clk);
        #1;
        check("model_rsp_valid", 32'(ext_rsp_valid), 32'(rv));
        if (ext_rsp_valid) rsp_count++;
        if (exp_rd_known) check("model_rsp_data", ext_rsp_data, exp_rd);
        if (exp_do_known) check("model_data_out", lm.data_out, exp_do);
    endtask

    vec_t vecs[23];

    initial begin
        // Directed table: each row is one cycle; expectations sampled after its clock edge.
        vecs[0]  = '{1, 5, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 5, 4'h0, 0,            0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'hDEADBEEF};
        vecs[2]  = '{1, 7, 4'hF, 32'hAAAAAAAA, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 7, 4'h5, 32'h11223344, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 32'hAAAAAAAA};
        vecs[4]  = '{0, 0, 4'h0, 0, 1, 7, 0, 4'h0, 0, 1, 0, 0, 0, 1, 32'hAAAAAAAA};
        vecs[5]  = '{0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 1, 32'hAA22AA44, 1, 32'hAAAAAAAA};
        vecs[6]  = '{0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 1, 32'hAA22AA44, 1, 32'hAAAAAAAA};
        vecs[7]  = '{1, 5, 4'h0, 0, 1, 7, 0, 4'h0, 0, 1, 0, 0, 0, 1, 32'hDEADBEEF};
        vecs[8]  = '{1, 7, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 32'hAA22AA44};
        vecs[9]  = '{1, 5, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF};
        vecs[10] = '{1, 7, 4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 32'hAA22AA44};
        vecs[11] = '{0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 1, 1, 1, 32'hAA22AA44, 1, 32'hAA22AA44};
        vecs[12] = '{0, 0, 4'h0, 0, 0, 0, 0, 4'h0, 0, 1, 0, 1, 32'hAA22AA44, 1, 32'hAA22AA44};
        vecs[13] = '{1, 3, 4'hF, 10, 1, 3, 0, 4'h0, 0, 1, 0, 1, 32'hAA22AA44, 0, 0};
        vecs[14] = '{1, 3, 4'h0, 0,  0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hAA22AA44, 1, 10};
        vecs[15] = '{1, 3, 4'hF, 15, 0, 0, 0, 4'h0, 0, 0, 0, 1, 32'hAA22AA44, 1, 10};
        vecs[16] = '{0, 0, 4'h0, 0,  0, 0, 0, 4'h0, 0, 1, 1, 1, 15, 1, 10};
        vecs[17] = '{0, 0, 4'h0, 0,  1, 30'(DEPTH + 2), 1, 4'hF, 32'h0BADF00D, 1, 0, 1, 15, 1, 10};
        vecs[18] = '{0, 0, 4'h0, 0,  0, 0, 0, 4'h0, 0, 1, 1, 0, 0, 1, 10};
        vecs[19] = '{1, 2, 4'h0, 0,  0, 0, 0, 4'h0, 0, 1, 0, 0, 0, 1, 32'h0BADF00D};
        vecs[20] = '{0, 0, 4'h0, 0,  1, 2, 1, 4'h3, 32'h12345678, 1, 0, 0, 0, 1, 32'h0BADF00D};
        vecs[21] = '{0, 0, 4'h0, 0,  0, 0, 0, 4'h0, 0, 1, 1, 1, 32'h0BADF00D, 1, 32'h0BADF00D};
        vecs[22] = '{1, 2, 4'h0, 0,  0, 0, 0, 4'h0, 0, 1, 0, 1, 32'h0BADF00D, 1, 32'h0BAD5678};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_rsp_valid", 32'(ext_rsp_valid), 0);
        check("reset_rsp_data", ext_rsp_data, 0);
        check("reset_data_out", lm.data_out, 0);
        check("reset_ready", 32'(ext_req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            drive(vecs[i].cen, vecs[i].caddr, vecs[i].cbe, vecs[i].cdata, vecs[i].ev,
                  vecs[i].eaddr, vecs[i].ewe, vecs[i].ebe, vecs[i].ewd);
            #1;
            check($sformatf("vec%0d_ready", i), 32'(ext_req_ready), 32'(vecs[i].x_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rsp_valid", i), 32'(ext_rsp_valid), 32'(vecs[i].x_rv));
            if (vecs[i].chk_rd) check($sformatf("vec%0d_rsp_data", i), ext_rsp_data, vecs[i].x_rd);
            if (vecs[i].chk_do) check($sformatf("vec%0d_data_out", i), lm.data_out, vecs[i].x_do);
        end

        // Reset while an external write to word 2 is pending: it must vanish.
        @(negedge clk);
        drive(1, 5, 0, 0, 1, 2, 1, 4'hF, 32'hFFFFFFFF);
        #1;
        check("rstpend_accept_ready", 32'(ext_req_ready), 1);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rstpend_rsp_valid", 32'(ext_rsp_valid), 0);
            check("rstpend_rsp_data", ext_rsp_data, 0);
            check("rstpend_data_out", lm.data_out, 0);
            check("rstpend_ready", 32'(ext_req_ready), 1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("rstpend_no_rsp", 32'(ext_rsp_valid), 0);
        end
        @(negedge clk);
        drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("rstpend_word_unchanged", lm.data_out, 32'h0BAD5678);

        // Hand the reference model the known state, then fill the array by streaming.
        for (int i = 0; i < int'(DEPTH); i++) known[i] = 1'b0;
        mem[2] = 32'h0BAD5678;
        known[2] = 1'b1;
        exp_do = 32'h0BAD5678;
        exp_do_known = 1'b1;
        exp_rd = 32'h0;
        exp_rd_known = 1'b1;
        rsp_count = 0;
        for (int i = 0; i < int'(DEPTH); i++)
            step(0, 0, 0, 0, 1, 30'(i), 1, 4'hF, $urandom);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("fill_rsp_count", 32'(rsp_count), 32'(DEPTH));

        // Eight back-to-back external writes with the core idle, then core readback.
        rsp_count = 0;
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 0, 1, 30'(20 + i), 1, 4'hF, 32'hC0DE0000 + 32'(i));
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("stream_rsp_count", 32'(rsp_count), 8);
        for (int i = 0; i < 8; i++) begin
            step(1, 30'(20 + i), 0, 0, 0, 0, 0, 0, 0);
            check("stream_readback", lm.data_out, 32'hC0DE0000 + 32'(i));
        end

        // Randomized mix: core traffic, wrapping addresses, partial lanes, external bursts.
        for (int n = 0; n < 1500; n++) begin
            logic        cen, ev, ewe;
            logic [3:0]  cbe, ebe;
            cen = ($urandom_range(0, 99) < 40);
            cbe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            ev  = ($urandom_range(0, 99) < 60);
            ewe = 1'($urandom);
            ebe = 4'($urandom);
            step(cen, 30'($urandom), cbe, $urandom, ev, 30'($urandom), ewe, ebe, $urandom);
        end
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("drain_queue_empty", 32'(pq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/local_mem_shared_ram.md
# local_mem_shared_ram

Single-port, word-organised local memory with byte-lane writes. It sits directly downstream of the core's local-memory sub-unit, on the `local_memory_interface` slave side. A secondary external request port with a valid/ready handshake lets a DMA or debug agent read and write the same array. Core accesses always win, because the core port has no stall. External accesses are buffered and issued in idle core cycles.

## Interface
- `DEPTH_WORDS`, 4096: number of 32-bit words; power of two, at least 2.
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `local_mem`  `local_memory_interface.slave`: `addr[29:0]`, `en`, `be[3:0]`, `data_in[31:0]`, `data_out[31:0]`.
- `ext_req_valid`  in  1  external request present.
- `ext_req_ready`  out  1  request accepted when valid and ready are both high.
- `ext_req_addr`  in  30  word address.
- `ext_req_we`  in  1  1 = write, 0 = read.
- `ext_req_be`  in  4  byte enables; ignored when `ext_req_we` = 0.
- `ext_req_wdata`  in  32  write data.
- `ext_rsp_valid`  out  1  one-cycle pulse per completed external request.
- `ext_rsp_data`  out  32  read data, held until the next response.

## Operation
**Address**
- Word index = `addr[log2(DEPTH_WORDS)-1:0]`.
- Upper bits are ignored, so addresses wrap. This applies to both ports.

**Core port**
- When `en` = 1, the array is accessed in that cycle.
- `be` = 0 is a read. `be` ≠ 0 writes only the enabled lanes.
- `data_out` is a dedicated register, updated only on core `en` cycles, with read-first semantics (the pre-write word).
- External traffic never disturbs `data_out`. This matters because the AMO read-modify-write sequence consumes `data_out` in the cycle after the read while `en` is high again.

**External port**
- One-entry holding register (`pend`, plus address/we/be/wdata).
- Issue condition: `pend` = 1 and core `en` = 0.
- `ext_req_ready` = !`pend` || issue. This gives back-to-back throughput of 1 per cycle while the core is idle.
- External reads and writes update the `ext_rsp_data` register with read-first semantics: a write returns the pre-write word.
- Every issued request, read or write, produces exactly one `ext_rsp_valid` pulse.

**Arbitration**
- The core has strict priority.
- An external request may wait indefinitely under continuous core `en`. This is permitted; agents must tolerate it.

**Collisions**
- Core and external accesses are never issued in the same cycle, so there are no RAM collisions.
- A write by one port is visible to a read by either port issued in any later cycle.

## Timing
**Reset**
- While `rst_n` = 0: `pend` = 0, `ext_rsp_valid` = 0, `ext_rsp_data` = 0, `data_out` = 0, and `ext_req_ready` = 1 from the first cycle after reset.
- Array contents are not reset.
- Reset during a pending request drops it silently: no response and no write.

**Latency**
- Core: request in cycle T, `data_out` valid in T+1.
- External, core idle: accepted in T, issued in T+1, `ext_rsp_valid` in T+2.
- Each cycle of core `en` while `pend` = 1 adds one cycle of latency.

**Handshake rules**
- `ext_req_ready` may depend combinationally on `local_mem.en`.
- Request fields are captured only on the accept edge.
- `ext_rsp_valid` has no backpressure; the agent must sink every pulse.

**Simultaneous events**
- Issue and new accept in the same cycle: the holding register reloads, and the response for the old request appears next cycle.
- Core `en` and external accept in the same cycle: the request is accepted if `pend` = 0, but not issued.

## Structure
- Shared package `cva5_config`/`cva5_types` gains an `ext_mem_req_t` struct (addr, we, be, wdata). The request ports may be bundled as this type at integration.
- One natural sub-module, `byte_en_ram`:
  - single-port array with per-lane write enable and read-first registered output;
  - parameterised by `DEPTH_WORDS`;
  - written so FPGA tools infer block RAM.
- The arbitration mux, `pend` register and two output registers live in `local_mem_shared_ram`.

## Test plan
1. **Core write/read:** core writes 0xDEADBEEF (be = 0xF) to word 5, then reads word 5 next cycle → `data_out` = 0xDEADBEEF one cycle after the read.
2. **Byte lanes:** core writes 0x11223344 (be = 0x5) over 0xAAAAAAAA at word 7; external read of word 7 → `ext_rsp_data` = 0xAA22AA44, `ext_rsp_valid` at T+2.
3. **Priority:**
   - hold core `en` for 4 cycles; external read accepted in the first cycle;
   - → `ext_req_ready` = 0 for cycles 2–4; response pulses 2 cycles after `en` drops;
   - → `data_out` carries only core reads.
4. **AMO pattern:**
   - core read of word 3 (holds 10), then core write of 15 to word 3 next cycle, with an external read of word 3 pending throughout;
   - → `data_out` = 10 in the write cycle;
   - → external response = 15 after the core finishes.
5. **Streaming:** 8 external writes back-to-back with the core idle → one accept per cycle, 8 response pulses; readback matches.
6. **Reset and wrap:**
   - reset asserted with `pend` = 1 → no response, target word unchanged;
   - external write to address `DEPTH_WORDS` + 2 → data lands in word 2.
